pipe_skidx: RTL and testbench
=============================

// Module: pipe_skidx
// PURPOSE
//   Two-entry valid/ready skid buffer that feeds the downstream fixed register pipeline.
//   It carries polynomial coefficient streams between Kyber datapath stages.
//   Full throughput is 1 beat/clk. Input ready and all outputs are registered, which
//   breaks the combinational ready path between producer and consumer.
//   Sync flush drops all in-flight data, for example on an operation abort.
// PARAMETERS
//   WIDTH        8                 data width in bits
//   RESET_VALUE  {WIDTH{1'b0}}     value loaded into odat and the skid register on rst/flush
// PORTS
//   clk    in   1      single clock; all logic is on its rising edge
//   rst    in   1      synchronous, active-high reset
//   flush  in   1      synchronous clear; same effect as rst, one cycle
//   ivld   in   1      upstream beat valid
//   idat   in   WIDTH  upstream beat data
//   irdy   out  1      registered; buffer can accept a beat this cycle
//   ovld   out  1      registered; odat holds a valid beat
//   odat   out  WIDTH  registered output data (main register)
//   ordy   in   1      downstream accepts the beat this cycle
//   occ    out  2      registered occupancy, 0..2
// BEHAVIOUR
//   - Handshake terms: acc = ivld & irdy & ~flush; take = ovld & ordy & ~flush.
//   - Reset, rst=1 sampled: state=EMPTY, ovld=0, irdy=1, occ=0.
//     odat and the skid register are both set to RESET_VALUE.
//   - flush=1: identical effect to rst. A beat offered in the same cycle is dropped,
//     and so is any downstream take. rst has priority over flush.
//   - FSM states are EMPTY, ONE and TWO.
//     - EMPTY: acc -> ONE, main<=idat.
//     - ONE:
//       - acc&~take -> TWO, skid<=idat.
//       - acc&take  -> ONE, main<=idat.
//       - ~acc&take -> EMPTY.
//       - otherwise the state holds.
//     - TWO: irdy=0, so no acc.
//       - take -> ONE, main<=skid.
//       - otherwise hold.
//   - Outputs decoded from the next state and registered:
//     - ovld = (state!=EMPTY).
//     - irdy = (state!=TWO).
//     - occ = 0/1/2 for EMPTY/ONE/TWO.
//   - Latency: a beat accepted in cycle N gives ovld=1 with odat=that beat in cycle N+1,
//     when the buffer was EMPTY or taken-through.
//   - Order is strict FIFO. No beat is duplicated or lost, except on flush/rst.
//   - Stability: while ovld=1 and ordy=0, odat and ovld hold unchanged.
//   - When ovld=0, odat holds its last value (RESET_VALUE after rst/flush).
//   - irdy may deassert without ordy having been low in the same cycle.
//     Producers obey irdy only, with no combinational dependency on ordy.
//   - Upstream holding ivld while irdy=0 is legal: the beat is held, not lost.
//   - An illegal state encoding recovers to EMPTY on the next clk.
// STRUCTURE
//   - Shared package: localparam state codes ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2.
//     The occ encoding equals the state code.
//   - Natural sub-module pipe_skid_ctl: FSM plus the load enables ld_main, sel_skid, ld_skid.
//     The top level holds the WIDTH-wide main/skid registers and the output mux.
//   - No other sub-modules. No async logic.
// TESTING
//   - Reset: assert rst 2 clk with ivld=1, idat=8'hA5.
//     Expect ovld=0, irdy=1, occ=0, odat=8'h00; no beat accepted.
//   - Streaming: ordy=1, drive 8'h01..8'h10 back-to-back.
//     Expect odat 8'h01..8'h10 on consecutive cycles, each 1 clk after its acc; irdy stays 1.
//   - Backpressure: send 8'h11, 8'h22, 8'h33 with ordy=0.
//     Expect occ=2 and irdy=0 after the 2nd beat; 8'h33 is held by upstream.
//     Then raise ordy: expect 8'h11, 8'h22, 8'h33 in order, no loss.
//   - Simultaneous: in ONE, ivld=1 and ordy=1 each cycle for 20 cycles.
//     Expect occ stays 1 and the output sequence equals the input sequence.
//   - Flush mid-stream: in TWO with 8'h44/8'h55 stored, pulse flush with ivld=1, idat=8'h66.
//     Expect next cycle ovld=0, occ=0, odat=8'h00; 8'h66 is dropped.
//   - Random: random ivld/ordy for 10k cycles with a scoreboard.
//     Expect FIFO order exact and occ==accepted-taken.
//     Expect odat to stay stable whenever ovld&~ordy.

Source files
------------

// File: rtl/pipe_skidx_pkg.sv
// -----------------------------------------------------------------------------
// pipe_skidx_pkg
//   Shared definitions for the two-entry skid buffer.
//   The state codes double as the occupancy count presented on occ:
//   EMPTY=0, ONE=1, TWO=2. Code 3 is illegal and recovers to EMPTY.
// -----------------------------------------------------------------------------
package pipe_skidx_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_ONE   = ST_ONE,
        S_TWO   = ST_TWO
    } state_e;

endpackage

// File: rtl/pipe_skid_ctl.sv
// -----------------------------------------------------------------------------
// pipe_skid_ctl
//   Control FSM for the two-entry skid buffer. Tracks how many beats are held
//   and produces the load enables for the datapath registers in the top level.
//   irdy, ovld and occ are registered and decoded from the next state, so
//   neither handshake side sees a combinational path from the other.
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   flush    in   synchronous clear, same effect as rst
//   ivld     in   upstream beat valid
//   ordy     in   downstream ready
//   irdy     out  registered, buffer can accept a beat
//   ovld     out  registered, main register holds a valid beat
//   occ      out  registered occupancy 0..2
//   ld_main  out  load the main (output) register this cycle
//   sel_skid out  main register loads from skid instead of idat
//   ld_skid  out  load the skid register from idat this cycle
// -----------------------------------------------------------------------------
module pipe_skid_ctl
    import pipe_skidx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       ivld,
    input  logic       ordy,
    output logic       irdy,
    output logic       ovld,
    output logic [1:0] occ,
    output logic       ld_main,
    output logic       sel_skid,
    output logic       ld_skid
);

    state_e     state_q, state_d;
    logic       irdy_q, ovld_q;
    logic [1:0] occ_q;
    logic       acc, take;

    // A flush cancels both handshakes of its own cycle.
    assign acc  = ivld & irdy_q & ~flush;
    assign take = ovld_q & ordy & ~flush;

    always_comb begin
        state_d  = state_q;
        ld_main  = 1'b0;
        sel_skid = 1'b0;
        ld_skid  = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (acc) begin
                    state_d = S_ONE;
                    ld_main = 1'b1;
                end
            end
            S_ONE: begin
                if (acc && !take) begin
                    state_d = S_TWO;
                    ld_skid = 1'b1;
                end else if (acc && take) begin
                    ld_main = 1'b1;
                end else if (take) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                // irdy is low here, so only the drain path exists.
                if (take) begin
                    state_d  = S_ONE;
                    ld_main  = 1'b1;
                    sel_skid = 1'b1;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q <= S_EMPTY;
            irdy_q  <= 1'b1;
            ovld_q  <= 1'b0;
            occ_q   <= ST_EMPTY;
        end else begin
            state_q <= state_d;
            irdy_q  <= (state_d != S_TWO);
            ovld_q  <= (state_d != S_EMPTY);
            occ_q   <= state_d;
        end
    end

    assign irdy = irdy_q;
    assign ovld = ovld_q;
    assign occ  = occ_q;

endmodule

// File: rtl/pipe_skidx.sv
// -----------------------------------------------------------------------------
// pipe_skidx
//   Two-entry valid/ready skid buffer for coefficient streams between datapath
//   stages. Sustains one beat per clock; irdy and all outputs are registered.
//   The main register drives odat directly; the skid register catches the beat
//   that arrives in the cycle the consumer stalls.
// Ports
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   flush  in   synchronous clear, drops all held beats
//   ivld   in   upstream beat valid
//   idat   in   upstream beat data [WIDTH]
//   irdy   out  registered, buffer can accept a beat
//   ovld   out  registered, odat holds a valid beat
//   odat   out  registered output data [WIDTH]
//   ordy   in   downstream accepts the beat
//   occ    out  registered occupancy 0..2
// -----------------------------------------------------------------------------
module pipe_skidx
    import pipe_skidx_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             ivld,
    input  logic [WIDTH-1:0] idat,
    output logic             irdy,
    output logic             ovld,
    output logic [WIDTH-1:0] odat,
    input  logic             ordy,
    output logic [1:0]       occ
);

    logic             ld_main, sel_skid, ld_skid;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;

    pipe_skid_ctl u_ctl (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .ivld     (ivld),
        .ordy     (ordy),
        .irdy     (irdy),
        .ovld     (ovld),
        .occ      (occ),
        .ld_main  (ld_main),
        .sel_skid (sel_skid),
        .ld_skid  (ld_skid)
    );

    // Main register refills from skid when draining TWO, else from upstream.
    always_comb begin
        main_d = sel_skid ? skid_q : idat;
        skid_d = idat;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_q <= RESET_VALUE;
            skid_q <= RESET_VALUE;
        end else begin
            if (ld_main) main_q <= main_d;
            if (ld_skid) skid_q <= skid_d;
        end
    end

    assign odat = main_q;

endmodule

// File: tb/tb_pipe_skidx.sv
// -----------------------------------------------------------------------------
// tb_pipe_skidx
//   Scoreboard bench for pipe_skidx. The driver changes inputs 1 time unit
//   after each rising edge; the monitor samples on the falling edge, decides
//   which handshakes the coming edge will complete, and keeps a queue of
//   expected beats plus the last delivered value.
// -----------------------------------------------------------------------------
module tb_pipe_skidx;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       ivld;
    logic [7:0] idat;
    logic       irdy;
    logic       ovld;
    logic [7:0] odat;
    logic       ordy;
    logic [1:0] occ;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_on = 1'b0;

    pipe_skidx #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .ivld  (ivld),
        .idat  (idat),
        .irdy  (irdy),
        .ovld  (ovld),
        .odat  (odat),
        .ordy  (ordy),
        .occ   (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model + monitor ----------------
    logic [7:0] q[$];
    logic [7:0] last_out = 8'h00;
    bit         stall_prev = 1'b0;
    logic [7:0] stall_dat = 8'h00;

    always @(negedge clk) begin
        if (mon_on) begin
            // Observable state must match the model before this edge's events.
            chk("occ", {30'd0, occ}, q.size());
            chk("ovld", {31'd0, ovld}, (q.size() != 0) ? 32'd1 : 32'd0);
            chk("irdy", {31'd0, irdy}, (q.size() < 2) ? 32'd1 : 32'd0);
            chk("odat", {24'd0, odat}, {24'd0, (q.size() != 0) ? q[0] : last_out});
            if (stall_prev) begin
                chk("stable_ovld", {31'd0, ovld}, 32'd1);
                chk("stable_odat", {24'd0, odat}, {24'd0, stall_dat});
            end
            stall_prev = ovld && !ordy && !flush && !rst;
            stall_dat  = odat;

            if (rst || flush) begin
                q.delete();
                last_out   = 8'h00;
                stall_prev = 1'b0;
            end else begin
                if (ovld && ordy) begin
                    if (q.size() == 0) begin
                        chk("take_from_empty", 32'd1, 32'd0);
                    end else begin
                        last_out = q.pop_front();
                    end
                end
                if (ivld && irdy) q.push_back(idat);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        ivld = 1'b1;
        idat = b;
        while (!irdy && n < 200) begin
            cyc();
            n++;
        end
        if (n >= 200) chk("send_timeout", 32'd1, 32'd0);
        cyc();
        ivld = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        ordy = 1'b1;
        while (ovld && n < 50) begin
            cyc();
            n++;
        end
        chk("drain_done", {31'd0, ovld}, 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        ivld  = 1'b1;
        idat  = 8'hA5;
        ordy  = 1'b0;

        // Reset held two cycles with a beat offered.
        repeat (2) cyc();
        chk("rst_ovld", {31'd0, ovld}, 32'd0);
        chk("rst_irdy", {31'd0, irdy}, 32'd1);
        chk("rst_occ",  {30'd0, occ},  32'd0);
        chk("rst_odat", {24'd0, odat}, 32'h00);
        rst  = 1'b0;
        ivld = 1'b0;
        cyc();
        chk("post_rst_ovld", {31'd0, ovld}, 32'd0);
        chk("post_rst_odat", {24'd0, odat}, 32'h00);
        mon_on = 1'b1;

        // Streaming at full rate.
        ordy = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            send(8'(i));
            chk("stream_ovld", {31'd0, ovld}, 32'd1);
            chk("stream_odat", {24'd0, odat}, i);
            chk("stream_irdy", {31'd0, irdy}, 32'd1);
        end
        drain();

        // Backpressure: two beats fill the buffer, third is held upstream.
        ordy = 1'b0;
        send(8'h11);
        send(8'h22);
        chk("bp_occ",  {30'd0, occ},  32'd2);
        chk("bp_irdy", {31'd0, irdy}, 32'd0);
        ivld = 1'b1;
        idat = 8'h33;
        repeat (3) cyc();
        chk("bp_hold_occ", {30'd0, occ}, 32'd2);
        chk("bp_hold_odat", {24'd0, odat}, 32'h11);
        ordy = 1'b1;
        send(8'h33);
        drain();

        // Simultaneous accept and take while in ONE.
        ordy = 1'b0;
        send(8'h80);
        ordy = 1'b1;
        ivld = 1'b1;
        for (int i = 0; i < 20; i++) begin
            idat = 8'h81 + 8'(i);
            cyc();
            chk("sim_occ", {30'd0, occ}, 32'd1);
            chk("sim_odat", {24'd0, odat}, 32'h81 + i);
        end
        ivld = 1'b0;
        drain();

        // Flush while TWO, with a beat offered in the same cycle.
        ordy = 1'b0;
        send(8'h44);
        send(8'h55);
        chk("fl_pre_occ", {30'd0, occ}, 32'd2);
        flush = 1'b1;
        ivld  = 1'b1;
        idat  = 8'h66;
        ordy  = 1'b1;
        cyc();
        flush = 1'b0;
        ivld  = 1'b0;
        chk("fl_ovld", {31'd0, ovld}, 32'd0);
        chk("fl_occ",  {30'd0, occ},  32'd0);
        chk("fl_odat", {24'd0, odat}, 32'h00);
        cyc();
        chk("fl_after_ovld", {31'd0, ovld}, 32'd0);

        // Random traffic; the monitor checks every cycle.
        for (int i = 0; i < 10000; i++) begin
            ivld  = ($urandom_range(0, 3) != 0);
            idat  = 8'($urandom);
            ordy  = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 299) == 0);
            cyc();
        end
        flush = 1'b0;
        ivld  = 1'b0;
        drain();
        repeat (2) cyc();
        mon_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
